// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, stall/flush and mult/div occupancy control; MULDIV_EN builds the mult/div tracker.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic       MulDivStartE,
  input  logic       MulDivOpD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MulDivBusy,
  output logic       MulDivDone
);
  logic lwstall, branchstall, mdstall, stall;
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return src != 5'd0 && src == dst;
  endfunction
  assign ForwardAE = (RegWriteM && hit(RsE, WriteRegM)) ? 2'b10 :
                     (RegWriteW && hit(RsE, WriteRegW)) ? 2'b01 : 2'b00;
  assign ForwardBE = (RegWriteM && hit(RtE, WriteRegM)) ? 2'b10 :
                     (RegWriteW && hit(RtE, WriteRegW)) ? 2'b01 : 2'b00;
  assign ForwardAD = RegWriteM && hit(RsD, WriteRegM);
  assign ForwardBD = RegWriteM && hit(RtD, WriteRegM);
  assign lwstall = MemtoRegE && (hit(RsD, RtE) || hit(RtD, RtE));
  assign branchstall = BranchD &&
    ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
     (MemtoRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
  assign stall = lwstall | branchstall | mdstall;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;
  assign FlushD = PCSrcD && !stall;
`ifdef MULDIV_EN
  localparam int CW = $clog2(MULDIV_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(MULDIV_CYCLES - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic done_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      MulDivDone <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      MulDivDone <= done_nx;
    end
  end
  // a start while busy (legal only at cnt==0) always restarts the count
  always_comb begin
    done_nx  = state == BUSY && cnt == '0;
    state_nx = (MulDivStartE || (state == BUSY && cnt != '0)) ? BUSY : IDLE;
    cnt_nx   = MulDivStartE ? RELOAD : (state == BUSY && cnt != '0) ? cnt - CW'(1) : '0;
  end
  assign MulDivBusy = state == BUSY;
  assign mdstall = MulDivOpD && (MulDivBusy || MulDivStartE);
`else
  logic unused_md;
  assign unused_md = ^{clk, rst_n, MulDivStartE, MulDivOpD};
  assign MulDivBusy = 1'b0;
  assign MulDivDone = 1'b0;
  assign mdstall = 1'b0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table plus mult/div and reset sequences; expectations flow through a queue.
module tb_pipeline_hazard_ctrl;
`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  typedef struct packed {
    logic stall, flushd, fad, fbd;
    logic [1:0] fae, fbe;
    logic busy, done;
  } exp_t;
  typedef struct packed {
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic [6:0] ctl;
    exp_t e;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD;
  logic MulDivStartE, MulDivOpD;
  logic StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MulDivBusy, MulDivDone;
  logic [1:0] ForwardAE, ForwardBE;
  int total = 0, bad = 0;
  exp_t exp_q[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
    .MulDivStartE(MulDivStartE), .MulDivOpD(MulDivOpD), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone)
  );

  function automatic vec_t v(input logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw,
                             input logic [6:0] ctl, input logic [3:0] f1, input logic [3:0] fw);
    vec_t r;
    r = '{rsd: rsd, rtd: rtd, rse: rse, rte: rte, wre: wre, wrm: wrm, wrw: wrw, ctl: ctl, e: '0};
    {r.e.stall, r.e.flushd, r.e.fad, r.e.fbd} = f1;
    {r.e.fae, r.e.fbe} = fw;
    return r;
  endfunction

  function automatic exp_t md_exp(input logic stall, input logic busy, input logic done);
    exp_t e;
    e = '0;
    e.stall = stall;
    e.busy = busy;
    e.done = done;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " StallF"}, int'(StallF), int'(e.stall));
    chk({tag, " StallD"}, int'(StallD), int'(e.stall));
    chk({tag, " FlushE"}, int'(FlushE), int'(e.stall));
    chk({tag, " FlushD"}, int'(FlushD), int'(e.flushd));
    chk({tag, " ForwardAD"}, int'(ForwardAD), int'(e.fad));
    chk({tag, " ForwardBD"}, int'(ForwardBD), int'(e.fbd));
    chk({tag, " ForwardAE"}, int'(ForwardAE), int'(e.fae));
    chk({tag, " ForwardBE"}, int'(ForwardBE), int'(e.fbe));
    chk({tag, " MulDivBusy"}, int'(MulDivBusy), int'(e.busy));
    chk({tag, " MulDivDone"}, int'(MulDivDone), int'(e.done));
  endtask

  task automatic drive(input vec_t x);
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = {x.rsd, x.rtd, x.rse, x.rte, x.wre, x.wrm, x.wrw};
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD} = x.ctl;
    exp_q.push_back(x.e);
  endtask

  task automatic md_cycle(input logic start, input logic op, input exp_t e, input string tag);
    MulDivStartE = start;
    MulDivOpD = op;
    exp_q.push_back(e);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rsd rtd rse rte wre wrm wrw | rwe rwm rww mre mrm br pcs | stall flushd fad fbd | fae fbe
    tbl[0]  = v(0, 0, 5, 0, 0, 5, 5, 7'b0110000, 4'b0000, 4'b1000);
    tbl[1]  = v(0, 0, 0, 0, 0, 5, 5, 7'b0110000, 4'b0000, 4'b0000);
    tbl[2]  = v(0, 0, 7, 2, 0, 2, 7, 7'b0110000, 4'b0000, 4'b0110);
    tbl[3]  = v(0, 0, 5, 0, 0, 5, 0, 7'b0000000, 4'b0000, 4'b0000);
    tbl[4]  = v(8, 0, 0, 8, 0, 0, 0, 7'b0001001, 4'b1000, 4'b0000);
    tbl[5]  = v(0, 0, 8, 0, 0, 8, 0, 7'b0100100, 4'b0000, 4'b1000);
    tbl[6]  = v(1, 9, 0, 9, 0, 0, 0, 7'b0001000, 4'b1000, 4'b0000);
    tbl[7]  = v(0, 0, 0, 0, 0, 0, 0, 7'b0001000, 4'b0000, 4'b0000);
    tbl[8]  = v(3, 0, 0, 0, 3, 0, 0, 7'b1000011, 4'b1000, 4'b0000);
    tbl[9]  = v(3, 0, 0, 0, 0, 3, 0, 7'b0100011, 4'b0110, 4'b0000);
    tbl[10] = v(4, 0, 0, 0, 0, 4, 0, 7'b0100111, 4'b1010, 4'b0000);
    tbl[11] = v(4, 0, 0, 0, 0, 0, 0, 7'b0000011, 4'b0100, 4'b0000);
    tbl[12] = v(0, 6, 0, 0, 6, 0, 0, 7'b1000010, 4'b1000, 4'b0000);
    tbl[13] = v(0, 6, 0, 0, 6, 0, 0, 7'b1000000, 4'b0000, 4'b0000);
    tbl[14] = v(0, 10, 0, 0, 0, 10, 0, 7'b0100000, 4'b0001, 4'b0000);
    tbl[15] = v(0, 0, 0, 0, 0, 0, 0, 7'b0100000, 4'b0000, 4'b0000);
    MulDivStartE = 1'b0;
    MulDivOpD = 1'b0;
    drive(v(0, 0, 0, 0, 0, 0, 0, 7'b0, 4'b0, 4'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      compare($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
    end
    drive(v(0, 0, 0, 0, 0, 0, 0, 7'b0, 4'b0, 4'b0));
    void'(exp_q.pop_back());
    md_cycle(1'b1, 1'b1, md_exp(MD, 1'b0, 1'b0), "md_start");
    for (int k = 1; k <= 8; k++) md_cycle(1'b0, 1'b1, md_exp(MD, MD, 1'b0), $sformatf("md_busy%0d", k));
    md_cycle(1'b0, 1'b1, md_exp(1'b0, 1'b0, MD), "md_done");
    md_cycle(1'b0, 1'b1, md_exp(1'b0, 1'b0, 1'b0), "md_after");
    md_cycle(1'b1, 1'b0, md_exp(1'b0, 1'b0, 1'b0), "rst_start");
    for (int k = 1; k <= 3; k++) md_cycle(1'b0, 1'b0, md_exp(1'b0, MD, 1'b0), $sformatf("rst_busy%0d", k));
    MulDivOpD = 1'b1;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(md_exp(1'b0, 1'b0, 1'b0));
    compare("rst_async");
    for (int k = 0; k < 2; k++) md_cycle(1'b0, 1'b1, md_exp(1'b0, 1'b0, 1'b0), $sformatf("rst_hold%0d", k));
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) md_cycle(1'b0, 1'b1, md_exp(1'b0, 1'b0, 1'b0), $sformatf("rst_idle%0d", k));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It drives the IF/ID register's enable and clear, the ID/EX clear, and the ID/EX forwarding selects. It also tracks the iterative multiply/divide unit so that HI/LO consumers wait for the result. The block sits beside the pipeline registers and is purely a control source: it holds no datapath values.

## Interface
Parameters:
- MULDIV_CYCLES, default 8: EX occupancy of one mult/div operation in cycles; legal range 2..64.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- RsD, RtD  in  5  source registers of the instruction in ID.
- RsE, RtE  in  5  source registers of the instruction in EX.
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers in EX, MEM and WB.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage.
- MemtoRegE, MemtoRegM  in  1  the instruction is a load.
- BranchD  in  1  the instruction in ID is a branch compared in ID.
- PCSrcD  in  1  the branch resolved taken in ID.
- MulDivStartE  in  1  a mult/div issues in EX this cycle.
- MulDivOpD  in  1  the instruction in ID reads HI/LO or is a mult/div.
- StallF, StallD  out  1  hold the PC and the IF/ID register.
- FlushD  out  1  clear IF/ID on the next edge.
- FlushE  out  1  clear ID/EX on the next edge.
- ForwardAD, ForwardBD  out  1  select the MEM result for the ID comparator.
- ForwardAE, ForwardBE  out  2  EX operand select: 00 = register file, 01 = WB, 10 = MEM.
- MulDivBusy  out  1  the mult/div unit is occupied.
- MulDivDone  out  1  registered one-cycle pulse when an operation completes.

## Operation
Register $0 never matches: every comparison below requires the source field to be nonzero.

Forwarding:
- ForwardAE = 10 if RegWriteM and WriteRegM == RsE.
- Otherwise ForwardAE = 01 if RegWriteW and WriteRegW == RsE.
- Otherwise ForwardAE = 00. ForwardBE uses the same rule on RtE.
- ForwardAD = RegWriteM and WriteRegM == RsD. ForwardBD uses the same rule on RtD.

Stall terms:
- lwstall = MemtoRegE and (RtE == RsD or RtE == RtD).
- branchstall = BranchD and either (RegWriteE and WriteRegE matches RsD or RtD) or (MemtoRegM and WriteRegM matches RsD or RtD).
- mdstall = MulDivOpD and (MulDivBusy or MulDivStartE).

Control outputs:
- stall = lwstall | branchstall | mdstall.
- StallF = StallD = FlushE = stall.
- FlushD = PCSrcD and not stall. A branch that is stalled is not treated as resolved.

Mult/div state machine (states IDLE and BUSY, down-counter cnt of width clog2(MULDIV_CYCLES)):
- IDLE with MulDivStartE: go to BUSY, cnt = MULDIV_CYCLES-1.
- BUSY with cnt > 0: cnt decrements by 1.
- BUSY with cnt == 0: MulDivDone = 1 in the next cycle. The state goes to IDLE, or reloads BUSY with cnt = MULDIV_CYCLES-1 if MulDivStartE is high on the same edge.
- MulDivStartE while BUSY with cnt > 0 is a protocol error: the counter reloads to MULDIV_CYCLES-1, and mdstall still applies.
- MulDivBusy = (state == BUSY).

## Timing
- While rst_n is low: state = IDLE, cnt = 0, MulDivBusy = 0, MulDivDone = 0.
- The combinational outputs follow their inputs during reset. An rst_n assertion mid-operation aborts any mult/div in progress immediately, with no Done pulse.
- Forward*, Stall*, FlushD and FlushE are combinational, valid in the same cycle as their inputs, with no added latency.
- A mult/div started at edge N drives MulDivBusy from N through N+MULDIV_CYCLES. MulDivDone is high for the cycle after edge N+MULDIV_CYCLES.
- A HI/LO reader held in ID is released in the cycle MulDivBusy falls.
- Simultaneous lwstall and PCSrcD: the stall wins and FlushD = 0. PCSrcD is reevaluated once the stall releases.
- A load-use stall lasts exactly 1 cycle. A branch behind an ALU op stalls 1 cycle; a branch behind a load stalls 2 cycles.

## Configuration
- MULDIV_EN defined: the state machine, counter, MulDivBusy, MulDivDone and mdstall behave as above.
- MULDIV_EN undefined: no state machine or counter is built. MulDivBusy = MulDivDone = 0, mdstall = 0, and MulDivStartE and MulDivOpD are ignored. All other behaviour is unchanged.

## Test plan
- Forwarding priority: RegWriteM = RegWriteW = 1, WriteRegM = WriteRegW = RsE = 5 -> ForwardAE = 10. With RsE = 0 instead -> ForwardAE = 00.
- Load-use: MemtoRegE = 1, RtE = 8, RsD = 8 -> StallF = StallD = FlushE = 1 for one cycle. After the pipeline advances the load to MEM -> ForwardAE = 10 and all stalls = 0.
- Branch hazard: BranchD = 1, RegWriteE = 1, WriteRegE = RsD = 3, PCSrcD = 1 -> stall = 1 and FlushD = 0. Next cycle (producer now in MEM, not a load) -> ForwardAD = 1, stall = 0, FlushD = 1.
- Mult/div, MULDIV_CYCLES = 8: pulse MulDivStartE, then hold MulDivOpD = 1 -> stall is held 9 cycles including the start cycle. MulDivDone pulses once, stall drops the same cycle MulDivBusy falls.
- Reset mid-operation: rst_n low 3 cycles into BUSY -> MulDivBusy = 0 asynchronously, no MulDivDone pulse, and the state is IDLE after release.
- MULDIV_EN undefined: the same mult/div stimulus -> no stall, MulDivBusy and MulDivDone stay 0.
